dadda_16x16_mult_reg: RTL and testbench



---
 rtl/dadda_16x16_mult_reg.sv | 143 ++++++++++++++
 tb/tb_dadda_16x16_mult_reg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dadda_16x16_mult_reg.sv
// Unsigned 16x16 Dadda multiplier built from full and half adders only.
// The 32-bit product is registered on the rising edge of clk.
module dadda_16x16_mult_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] final_result
);

    localparam int N_STAGES = 6;
    localparam int N_COLS   = 32;
    localparam int DEPTH    = 32;

    // Dadda height targets for each reduction stage, tallest first.
    function automatic int stage_target(input int s);
        case (s)
            0:       return 13;
            1:       return 9;
            2:       return 6;
            3:       return 4;
            4:       return 3;
            default: return 2;
        endcase
    endfunction

    // bits[s][k][h]: bit h of column k at the input of stage s.
    logic        bits [0:N_STAGES][0:N_COLS-1][0:DEPTH-1];
    int          ht   [0:N_COLS-1];
    int          nht  [0:N_COLS-1];
    logic        carr [0:DEPTH-1];
    logic        ncarr[0:DEPTH-1];
    int          ncin;
    int          nco;
    int          nh;
    int          pos;
    int          excess;
    int          n_fa;
    int          n_ha;
    logic        x0, x1, x2;
    logic [31:0] row0;
    logic [31:0] row1;
    logic [31:0] product;

    // The loops below are bounded by constants and every height value is
    // derived from constants, so the whole block unrolls into a fixed tree.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves a value held over, which is what would infer a latch.
        for (int s = 0; s <= N_STAGES; s++)
            for (int k = 0; k < N_COLS; k++)
                for (int h = 0; h < DEPTH; h++)
                    bits[s][k][h] = 1'b0;
        for (int k = 0; k < N_COLS; k++) begin
            ht[k]  = 0;
            nht[k] = 0;
        end
        for (int c = 0; c < DEPTH; c++) begin
            carr[c]  = 1'b0;
            ncarr[c] = 1'b0;
        end
        ncin = 0; nco = 0; nh = 0; pos = 0;
        excess = 0; n_fa = 0; n_ha = 0;
        x0 = 1'b0; x1 = 1'b0; x2 = 1'b0;

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                bits[0][i+j][5'(ht[i+j])] = a[j] & b[i];
                ht[i+j] = ht[i+j] + 1;
            end

        for (int s = 0; s < N_STAGES; s++) begin
            ncin = 0;
            for (int k = 0; k < N_COLS; k++) begin
                nh  = 0;
                pos = 0;
                nco = 0;
                // Carries produced by column k-1 in this stage land here.
                for (int c = 0; c < DEPTH; c++)
                    if (c < ncin) begin
                        bits[s+1][k][5'(nh)] = carr[c];
                        nh = nh + 1;
                    end
                excess = ht[k] + ncin - stage_target(s);
                if (excess < 0)
                    excess = 0;
                n_fa = excess / 2;
                n_ha = excess % 2;
                for (int f = 0; f < 16; f++)
                    if (f < n_fa) begin
                        x0 = bits[s][k][5'(pos)];
                        x1 = bits[s][k][5'(pos + 1)];
                        x2 = bits[s][k][5'(pos + 2)];
                        bits[s+1][k][5'(nh)] = x0 ^ x1 ^ x2;
                        ncarr[5'(nco)]       = (x0 & x1) | (x0 & x2) | (x1 & x2);
                        nh  = nh + 1;
                        nco = nco + 1;
                        pos = pos + 3;
                    end
                if (n_ha == 1) begin
                    x0 = bits[s][k][5'(pos)];
                    x1 = bits[s][k][5'(pos + 1)];
                    bits[s+1][k][5'(nh)] = x0 ^ x1;
                    ncarr[5'(nco)]       = x0 & x1;
                    nh  = nh + 1;
                    nco = nco + 1;
                    pos = pos + 2;
                end
                for (int h = 0; h < DEPTH; h++)
                    if (h >= pos && h < ht[k]) begin
                        bits[s+1][k][5'(nh)] = bits[s][k][h];
                        nh = nh + 1;
                    end
                nht[k] = nh;
                for (int c = 0; c < DEPTH; c++)
                    carr[c] = ncarr[c];
                ncin = nco;
            end
            for (int k = 0; k < N_COLS; k++)
                ht[k] = nht[k];
        end
    end

    always_comb begin
        for (int k = 0; k < N_COLS; k++) begin
            row0[k] = bits[N_STAGES][k][0];
            row1[k] = bits[N_STAGES][k][1];
        end
    end

    // Carry out of bit 31 can never be set for a 16x16 unsigned product.
    assign product = row0 + row1;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            final_result <= 32'h0;
        else
            final_result <= product;
    end

endmodule

// File: tb/tb_dadda_16x16_mult_reg.sv
// Self-checking bench for dadda_16x16_mult_reg: directed corner cases plus
// random and single-bit operand sweeps against a plain arithmetic reference.
module tb_dadda_16x16_mult_reg;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] final_result;

    int n_vectors;
    int n_miscompares;

    dadda_16x16_mult_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .final_result (final_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %08h expected %08h (a=%04h b=%04h)", tag, got, exp, a, b);
        end
    endtask

    function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    // Drive on the falling edge, capture on the next rising edge, sample 1ns later.
    task automatic apply(input string tag, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check(tag, final_result, ref_mult(x, y));
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst_n = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;

        #1;
        check("reset_initial", final_result, 32'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_held", final_result, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", final_result, 32'hFFFE0001);

        apply("small_ff_aa", 16'h00FF, 16'h00AA);
        check("const_a956", final_result, 32'h0000A956);
        apply("small_ff_ff", 16'h00FF, 16'h00FF);
        check("const_fe01", final_result, 32'h0000FE01);
        apply("small_ff_01", 16'h00FF, 16'h0001);
        check("const_00ff", final_result, 32'h000000FF);
        apply("small_ff_00", 16'h00FF, 16'h0000);
        check("const_zero", final_result, 32'h00000000);
        apply("small_ff_02", 16'h00FF, 16'h0002);
        check("const_01fe", final_result, 32'h000001FE);
        apply("a_zero", 16'h0000, 16'hBEEF);
        apply("full_aaaa", 16'hFFFF, 16'hAAAA);
        check("const_aaa95556", final_result, 32'hAAA95556);
        apply("full_max", 16'hFFFF, 16'hFFFF);
        check("const_fffe0001", final_result, 32'hFFFE0001);

        // Inputs changing between edges must not reach the output early.
        apply("latency_base", 16'h1234, 16'h5678);
        #2;
        a = 16'h9ABC;
        b = 16'hDEF0;
        #1;
        check("latency_hold", final_result, ref_mult(16'h1234, 16'h5678));
        @(negedge clk);
        check("latency_hold_neg", final_result, ref_mult(16'h1234, 16'h5678));
        @(posedge clk);
        #1;
        check("latency_update", final_result, ref_mult(16'h9ABC, 16'hDEF0));

        // Asynchronous clear between edges.
        apply("async_pre", 16'hFFFF, 16'h8001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", final_result, 32'h0);
        @(posedge clk);
        #1;
        check("async_hold", final_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                apply("single_bit", 16'(1 << i), 16'(1 << j));

        for (int n = 0; n < 10000; n++)
            apply("random", 16'($urandom), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
